// File: rtl/alu_ctrl_decoder.sv
// Decode/issue stage for the 8-bit ALU: registers the control word into the ID/EX slot
// and owns the carry flag. Optional illegal-opcode trap FSM: ALU_ILLEGAL_TRAP_EN.
module alu_ctrl_decoder #(
  parameter int INSTR_W = 8,
  parameter int RA_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_ctrl,
  output logic               out_carryin,
  output logic [RA_W-1:0]    out_rd,
  output logic [RA_W-1:0]    out_rs,
  output logic               out_rd_we,
  input  logic               alu_carryout,
  output logic               c_flag,
  output logic               illegal,
  output logic               trap,
  input  logic               trap_clear
);

  typedef enum logic [0:0] {RUN = 1'b0, TRAP = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [5:0]        ctrl_q, ctrl_d;
  logic              cin_q, cin_d;
  logic [RA_W-1:0]   rd_q, rd_d, rs_q, rs_d;
  logic              we_q, we_d;
  logic              setsc_q, setsc_d;
  logic              c_q, c_d;
  logic              ill_q, ill_d;

  logic [3:0]        opcode_s;
  logic              fire_s, accept_s, cf_s;
  logic              dec_slot_s, dec_cin_s, dec_we_s, dec_setsc_s;
  logic              dec_clc_s, dec_sec_s, dec_ill_s;
  logic [5:0]        dec_ctrl_s;

  assign opcode_s = in_instr[INSTR_W-1 -: 4];
  assign fire_s   = valid_q & out_ready;
  assign in_ready = (~valid_q | out_ready) & ~flush & (state_q == RUN);
  assign accept_s = in_valid & in_ready;
  // Forward the retiring op's carry so ADC/SBC never need to stall behind ADD/SUB.
  assign cf_s     = (fire_s & setsc_q) ? alu_carryout : c_q;

  // Opcode table decode
  always_comb begin
    dec_slot_s  = 1'b0;
    dec_ctrl_s  = 6'b000000;
    dec_cin_s   = 1'b0;
    dec_we_s    = 1'b0;
    dec_setsc_s = 1'b0;
    dec_clc_s   = 1'b0;
    dec_sec_s   = 1'b0;
    dec_ill_s   = 1'b0;
    case (opcode_s)
      4'h0: dec_slot_s = 1'b0;
      4'h1: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b000000; dec_cin_s = 1'b0; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h2: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b000000; dec_cin_s = cf_s; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h3: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b010000; dec_cin_s = 1'b1; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h4: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b010000; dec_cin_s = cf_s; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h5: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b001000; dec_cin_s = 1'b0; dec_we_s = 1'b1; dec_setsc_s = 1'b0; end
      4'h6: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b001100; dec_cin_s = 1'b0; dec_we_s = 1'b1; dec_setsc_s = 1'b0; end
      4'h7: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b010011; dec_cin_s = 1'b1; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h8: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b000011; dec_cin_s = 1'b0; dec_we_s = 1'b1; dec_setsc_s = 1'b1; end
      4'h9: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b010001; dec_cin_s = 1'b0; dec_we_s = 1'b1; dec_setsc_s = 1'b0; end
      4'hA: begin dec_slot_s = 1'b1; dec_ctrl_s = 6'b010000; dec_cin_s = 1'b1; dec_we_s = 1'b0; dec_setsc_s = 1'b1; end
      4'hB: dec_clc_s = 1'b1;
      4'hC: dec_sec_s = 1'b1;
      default: dec_ill_s = 1'b1;
    endcase
  end

  // Slot, carry flag, illegal pulse and trap FSM next state
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    cin_d   = cin_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    we_d    = we_q;
    setsc_d = setsc_q;
    c_d     = c_q;
    state_d = state_q;
    ill_d   = accept_s & dec_ill_s;

    if (accept_s & dec_slot_s) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl_s;
      cin_d   = dec_cin_s;
      rd_d    = in_instr[2*RA_W-1 -: RA_W];
      rs_d    = in_instr[RA_W-1:0];
      we_d    = dec_we_s;
      setsc_d = dec_setsc_s;
    end else if (fire_s | flush) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (accept_s & dec_clc_s) begin
      c_d = 1'b0;
    end else if (accept_s & dec_sec_s) begin
      c_d = 1'b1;
    end else if (fire_s & setsc_q) begin
      c_d = alu_carryout;
    end else begin
      c_d = c_q;
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    case (state_q)
      RUN:     if (accept_s & dec_ill_s) state_d = TRAP; else state_d = RUN;
      TRAP:    if (trap_clear) state_d = RUN; else state_d = TRAP;
      default: state_d = RUN;
    endcase
`else
    state_d = RUN;
`endif
  end

`ifndef ALU_ILLEGAL_TRAP_EN
  logic unused_trap_clear_s;
  assign unused_trap_clear_s = trap_clear;
`endif

  // Registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      ctrl_q  <= 6'b000000;
      cin_q   <= 1'b0;
      rd_q    <= '0;
      rs_q    <= '0;
      we_q    <= 1'b0;
      setsc_q <= 1'b0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      cin_q   <= cin_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      we_q    <= we_d;
      setsc_q <= setsc_d;
      c_q     <= c_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_carryin = cin_q;
  assign out_rd      = rd_q;
  assign out_rs      = rs_q;
  assign out_rd_we   = we_q;
  assign c_flag      = c_q;
  assign illegal     = ill_q;
  assign trap        = (state_q == TRAP);

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Randomized scoreboard bench for alu_ctrl_decoder; an opcode-table model predicts each
// issued control word, a monitor compares it whenever the slot fires.
module tb_alu_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0] in_instr;
  logic [5:0] out_ctrl;
  logic       out_carryin, out_rd_we, alu_carryout, c_flag, illegal, trap, trap_clear;
  logic [1:0] out_rd, out_rs;

  int checks = 0;
  int errors = 0;

  alu_ctrl_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_carryin(out_carryin), .out_rd(out_rd), .out_rs(out_rs), .out_rd_we(out_rd_we),
    .alu_carryout(alu_carryout), .c_flag(c_flag), .illegal(illegal), .trap(trap),
    .trap_clear(trap_clear)
  );

  always #5 clk = ~clk;

  // Opcode table: ctrl, carry-in (2 = forwarded carry), rd write, sets C
  logic [5:0] tbl_ctrl [16] = '{6'b000000, 6'b000000, 6'b000000, 6'b010000, 6'b010000, 6'b001000,
                                6'b001100, 6'b010011, 6'b000011, 6'b010001, 6'b010000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000};
  int         tbl_cin  [16] = '{0, 0, 2, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  logic       tbl_we   [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       tbl_sc   [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic [11:0] exp_q [$];
  logic        m_valid, m_setsc, m_c, m_ill, m_trap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_setsc = 1'b0; m_c = 1'b0; m_ill = 1'b0; m_trap = 1'b0;
    exp_q.delete();
  endtask

  // One clock: check registered state, drive inputs, check in_ready, advance the model.
  task automatic cycle(input logic v, input logic [7:0] ins, input logic ordy,
                       input logic fl, input logic aco, input logic tc);
    logic       exp_rdy, fire, cf, acc, nc, cin;
    logic [3:0] op;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("c_flag", c_flag, m_c);
    chk("illegal", illegal, m_ill);
    chk("trap", trap, m_trap);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    alu_carryout = aco; trap_clear = tc;
    #1;
    exp_rdy = (!m_valid || ordy) && !fl && !m_trap;
    chk("in_ready", in_ready, exp_rdy);
    fire = m_valid && ordy;
    cf   = (fire && m_setsc) ? aco : m_c;
    acc  = v && exp_rdy;
    op   = ins[7:4];
    nc   = m_c;
    if (acc && op == 4'hB) nc = 1'b0;
    else if (acc && op == 4'hC) nc = 1'b1;
    else if (fire && m_setsc) nc = aco;
    m_ill = acc && (op >= 4'hD);
    if (acc && op >= 4'h1 && op <= 4'hA) begin
      cin = (tbl_cin[op] == 2) ? cf : (tbl_cin[op] == 1);
      exp_q.push_back({tbl_ctrl[op], cin, ins[3:2], ins[1:0], tbl_we[op]});
      m_valid = 1'b1;
      m_setsc = tbl_sc[op];
    end else if (fire) begin
      m_valid = 1'b0;
    end else if (fl && m_valid) begin
      m_valid = 1'b0;
      void'(exp_q.pop_back());
    end
    m_c = nc;
`ifdef ALU_ILLEGAL_TRAP_EN
    if (m_ill) m_trap = 1'b1;
    else if (m_trap && tc) m_trap = 1'b0;
`endif
  endtask

  // Monitor: whenever the slot is consumed, compare it with the oldest prediction
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {20'd0, out_ctrl, out_carryin, out_rd, out_rs, out_rd_we}, 32'hFFFF_FFFF);
      end else begin
        chk("issued_word", {20'd0, out_ctrl, out_carryin, out_rd, out_rs, out_rd_we},
            {20'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 8'h00; out_ready = 1'b0; flush = 1'b0;
    alu_carryout = 1'b0; trap_clear = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 6'b000000);
    chk("rst_carryin", out_carryin, 1'b0);
    chk("rst_rd_rs_we", {out_rd, out_rs, out_rd_we}, 5'b00000);
    chk("rst_c_illegal_trap", {c_flag, illegal, trap}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD/SUB/AND stream at full throughput
    cycle(1'b1, 8'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h39, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // SEC then ADC, CLC then SBC
    cycle(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    // ADD retiring with carryout=1 on the edge ADC is accepted
    cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Back-pressure for three cycles, then flush the held ADD
    cycle(1'b1, 8'h1B, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Illegal opcode
    cycle(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    // Asynchronous reset with a held op and C=1
    cycle(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_c_flag", c_flag, 1'b0);
    chk("async_rst_ctrl", out_ctrl, 6'b000000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
